counter_arbiter: RTL and testbench

Shares a single WIDTH-bit down-counter between two requesters. Each requester asks for a timed interval of `len+1` cycles. The block grants round-robin, loads and runs the counter for the granted requester, and signals completion with a one-cycle done pulse. It sits in front of the shared counting resource, so requesters never drive the counter directly.

---
 rtl/counter_arbiter.sv | 136 +++++++++++++
 tb/tb_counter_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_arbiter                                              |
// | Description : Round-robin arbiter sharing one down-counter between two     |
// |               requesters; runs len+1 cycle intervals with a done pulse.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module counter_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0] c_zero = '0;
   localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state, w_state;
   logic             r_gnt0, w_gnt0;
   logic             r_gnt1, w_gnt1;
   logic             r_done0, w_done0;
   logic             r_done1, w_done1;
   logic             r_busy, w_busy;
   logic [WIDTH-1:0] r_count, w_count;
   logic             r_last, w_last;
   logic             w_own_req;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_gnt0  <= 1'b0;
         r_gnt1  <= 1'b0;
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;
         r_busy  <= 1'b0;
         r_count <= c_zero;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state;
         r_gnt0  <= w_gnt0;
         r_gnt1  <= w_gnt1;
         r_done0 <= w_done0;
         r_done1 <= w_done1;
         r_busy  <= w_busy;
         r_count <= w_count;
         r_last  <= w_last;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_gnt0    = r_gnt0;
      w_gnt1    = r_gnt1;
      w_done0   = 1'b0;
      w_done1   = 1'b0;
      w_count   = r_count;
      w_last    = r_last;
      // While running, r_last always names the current owner.
      w_own_req = r_last ? req1 : req0;

      case (r_state)
         S_IDLE: begin
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
            w_count = c_zero;
            if (req0 && (!req1 || r_last)) begin
               w_state = S_RUN;
               w_gnt0  = 1'b1;
               w_count = len0;
               w_last  = 1'b0;
            end else if (req1) begin
               w_state = S_RUN;
               w_gnt1  = 1'b1;
               w_count = len1;
               w_last  = 1'b1;
            end
         end
         S_RUN: begin
            if (!w_own_req) begin
               w_state = S_IDLE;
               w_gnt0  = 1'b0;
               w_gnt1  = 1'b0;
               w_count = c_zero;
            end else if (r_count != c_zero) begin
               w_count = r_count - c_one;
            end else begin
               w_state = S_DONE;
               w_gnt0  = 1'b0;
               w_gnt1  = 1'b0;
               w_done0 = !r_last;
               w_done1 = r_last;
               w_count = c_zero;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
            w_count = c_zero;
         end
         default: begin
            w_state = S_IDLE;
            w_gnt0  = 1'b0;
            w_gnt1  = 1'b0;
            w_count = c_zero;
         end
      endcase

      w_busy = (w_state != S_IDLE);
   end

   assign gnt0  = r_gnt0;
   assign gnt1  = r_gnt1;
   assign done0 = r_done0;
   assign done1 = r_done1;
   assign busy  = r_busy;
   assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_counter_arbiter                                           |
// | Description : Vector table, directed corner cases and random traffic       |
// |               checked against a transaction-level reference model.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_counter_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [3:0] len0 = '0, len1 = '0;
   logic       gnt0, gnt1, done0, done1, busy;
   logic [3:0] count;

   int n_checks = 0;
   int n_errors = 0;

   counter_arbiter #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .len0(len0), .req1(req1), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the counter, how far into its interval it is,
   // and who (if anyone) is in the done cycle.
   int m_owner, m_elapsed, m_len, m_done_who, m_last;

   task automatic model_reset();
      m_owner = -1; m_elapsed = 0; m_len = 0; m_done_who = -1; m_last = 1;
   endtask

   task automatic model_edge(input bit r, input bit q0, input int l0,
                             input bit q1, input int l1);
      bit q [2];
      int l [2];
      q[0] = q0; q[1] = q1; l[0] = l0; l[1] = l1;
      if (!r) begin
         model_reset();
      end else if (m_done_who >= 0) begin
         m_done_who = -1;
      end else if (m_owner >= 0) begin
         if (!q[m_owner]) m_owner = -1;
         else if (m_elapsed == m_len) begin
            m_done_who = m_owner;
            m_owner = -1;
         end else m_elapsed++;
      end else if (q0 || q1) begin
         m_owner   = (q0 && q1) ? 1 - m_last : (q0 ? 0 : 1);
         m_last    = m_owner;
         m_len     = l[m_owner];
         m_elapsed = 0;
      end
   endtask

   function automatic logic [8:0] model_out();
      logic [3:0] c;
      c = (m_owner >= 0) ? 4'(m_len - m_elapsed) : 4'd0;
      return {m_owner == 0, m_owner == 1, m_done_who == 0, m_done_who == 1,
              (m_owner >= 0) || (m_done_who >= 0), c};
   endfunction

   function automatic logic [8:0] dut_out();
      return {gnt0, gnt1, done0, done1, busy, count};
   endfunction

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got g0g1d0d1b=%b count=%0d, expected g0g1d0d1b=%b count=%0d",
                  name, act[8:4], act[3:0], exp[8:4], exp[3:0]);
      end
   endtask

   // One cycle: drive at negedge, advance model at posedge, compare after it.
   task automatic step(input bit r, input bit q0, input logic [3:0] l0,
                       input bit q1, input logic [3:0] l1);
      @(negedge clk);
      rst = r; req0 = q0; len0 = l0; req1 = q1; len1 = l1;
      @(posedge clk);
      model_edge(r, q0, int'(l0), q1, int'(l1));
      #1;
      check("model", dut_out(), model_out());
   endtask

   typedef struct {
      bit         r;
      bit         q0;
      logic [3:0] l0;
      bit         q1;
      logic [3:0] l1;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl [23];

   initial begin
      bit rq0, rq1, rr;

      // {rst, req0, len0, req1, len1, {gnt0,gnt1,done0,done1,busy,count}}
      tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[2]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, {5'b10001, 4'd3}};
      tbl[3]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, {5'b10001, 4'd2}};
      tbl[4]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, {5'b10001, 4'd1}};
      tbl[5]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, {5'b10001, 4'd0}};
      tbl[6]  = '{1'b1, 1'b1, 4'd3, 1'b0, 4'd0, {5'b00101, 4'd0}};
      tbl[7]  = '{1'b1, 1'b0, 4'd3, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[8]  = '{1'b1, 1'b0, 4'd3, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[10] = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, {5'b00000, 4'd0}};
      tbl[11] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b10001, 4'd2}};
      tbl[12] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b10001, 4'd1}};
      tbl[13] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b10001, 4'd0}};
      tbl[14] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b00101, 4'd0}};
      tbl[15] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b00000, 4'd0}};
      tbl[16] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b01001, 4'd1}};
      tbl[17] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b01001, 4'd0}};
      tbl[18] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b00011, 4'd0}};
      tbl[19] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b00000, 4'd0}};
      tbl[20] = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd1, {5'b10001, 4'd2}};
      tbl[21] = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd1, {5'b00000, 4'd0}};
      tbl[22] = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd1, {5'b00000, 4'd0}};

      model_reset();

      // Reset held with random inputs: everything must stay quiet.
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
         check("reset_hold", dut_out(), 9'd0);
      end

      // Single request, tie/round-robin, abort back to idle.
      for (int i = 0; i < 23; i++) begin
         step(tbl[i].r, tbl[i].q0, tbl[i].l0, tbl[i].q1, tbl[i].l1);
         check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      end

      // Zero length on requester 1.
      step(1'b1, 1'b0, 4'd0, 1'b1, 4'd0);
      check("zero_len_gnt", dut_out(), {5'b01001, 4'd0});
      step(1'b1, 1'b0, 4'd0, 1'b1, 4'd0);
      check("zero_len_done", dut_out(), {5'b00011, 4'd0});
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      check("zero_len_idle", dut_out(), 9'd0);

      // Abort of requester 1 with requester 0 pending.
      step(1'b1, 1'b0, 4'd5, 1'b1, 4'd9);
      check("abort_gnt", dut_out(), {5'b01001, 4'd9});
      step(1'b1, 1'b1, 4'd5, 1'b1, 4'd9);
      check("abort_run8", dut_out(), {5'b01001, 4'd8});
      step(1'b1, 1'b1, 4'd5, 1'b1, 4'd9);
      check("abort_run7", dut_out(), {5'b01001, 4'd7});
      step(1'b1, 1'b1, 4'd5, 1'b0, 4'd9);
      check("abort_drop", dut_out(), 9'd0);
      step(1'b1, 1'b1, 4'd5, 1'b0, 4'd9);
      check("abort_next_gnt", dut_out(), {5'b10001, 4'd5});
      step(1'b1, 1'b0, 4'd5, 1'b0, 4'd9);
      check("abort_idle", dut_out(), 9'd0);

      // Reset in the middle of a long interval.
      step(1'b1, 1'b1, 4'd15, 1'b0, 4'd0);
      check("rst_run_gnt", dut_out(), {5'b10001, 4'd15});
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd15, 1'b0, 4'd0);
      check("rst_run_cnt", dut_out(), {5'b10001, 4'd11});
      #2 rst = 1'b0;
      model_reset();
      #1 check("rst_async", dut_out(), 9'd0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 4'd15, 1'($urandom), 4'($urandom));
         check("rst_hold_nodone", dut_out(), 9'd0);
      end
      step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
      step(1'b1, 1'b1, 4'd2, 1'b1, 4'd3);
      check("rst_tie_gnt0", dut_out(), {5'b10001, 4'd2});

      // Random traffic against the model.
      rq0 = 1'b1; rq1 = 1'b1;
      for (int i = 0; i < 600; i++) begin
         if (rq0) rq0 = ($urandom_range(0, 9) != 0); else rq0 = ($urandom_range(0, 2) == 0);
         if (rq1) rq1 = ($urandom_range(0, 9) != 0); else rq1 = ($urandom_range(0, 2) == 0);
         rr = ($urandom_range(0, 99) != 0);
         step(rr, rq0, 4'($urandom_range(0, 15)), rq1, 4'($urandom_range(0, 15)));
         if (gnt0 && gnt1) begin
            n_checks++; n_errors++;
            $display("FAIL gnt_exclusive: got gnt0=%b gnt1=%b, expected at most one", gnt0, gnt1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
